alu_cmd_sequencer: RTL and testbench
====================================

# alu_cmd_sequencer

Command sequencer directly upstream of the 4-bit registered ALU stage. It queues operand/opcode commands from a host over a valid/ready interface, issues at most one per cycle to the ALU (`alu_a`, `alu_b`, `alu_op`, `alu_en`), and returns each ALU result with its command id over a valid/ready response interface. It guarantees that no ALU result is overwritten before the response consumer has accepted it.

## Interface
- `DEPTH`, default 4: command queue depth; power of two, at least 2.
- `ID_W`, default 3: width of the command id carried from command to response.
- `clk` in 1: single clock; everything is on its rising edge.
- `rst` in 1: synchronous, active-high reset (one clock; reset is synchronous and active-high).
- `cmd_valid` in 1: host command present.
- `cmd_ready` out 1: queue can accept a command; equals `count < DEPTH`.
- `cmd_a` in 4: operand A.
- `cmd_b` in 4: operand B.
- `cmd_op` in 2: opcode. 00 ADD, 01 AND, 10 MUL, 11 OR.
- `cmd_id` in ID_W: host tag.
- `alu_a` out 4: operand A to the ALU; queue head, 0 when empty.
- `alu_b` out 4: operand B to the ALU; queue head, 0 when empty.
- `alu_op` out 2: opcode to the ALU; queue head, 0 when empty.
- `alu_en` out 1: issue strobe; the ALU registers its result on this edge.
- `alu_result` in 4: registered ALU result.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_data` out 4: equals `alu_result` (pass-through).
- `rsp_op` out 2: opcode of the responding command.
- `rsp_id` out ID_W: id of the responding command.
- `count` out $clog2(DEPTH)+1: current queue occupancy.

## Operation
- Push: when `cmd_valid && cmd_ready`, write {a, b, op, id} at the write pointer.
- Issue condition: `issue = (count != 0) && (!rsp_valid || rsp_ready)`. `alu_en = issue`.
  - This is a combinational path from `rsp_ready`. This is intentional and is the only combinational input-to-output path.
- On an issue edge:
  - Pop the head.
  - Latch the head's op and id into `rsp_op` and `rsp_id`.
  - Set `rsp_valid` to 1.
- Response retire: on `rsp_valid && rsp_ready` with no issue in the same cycle, clear `rsp_valid` to 0.
- Issue and retire in the same cycle: `rsp_valid` stays 1 and carries the new command. This gives back-to-back throughput of 1 per cycle.
- While `rsp_valid && !rsp_ready`:
  - `alu_en` = 0, so the ALU holds its result.
  - `rsp_*` are stable.
- Simultaneous push and pop: `count` is unchanged and pointers advance independently.
  - When full, `cmd_ready` = 0 even if a pop occurs in that cycle. There is no ready-through-pop path.
- No bypass: a command pushed into an empty queue issues no earlier than the next cycle.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full and empty are decided by `count` only.
- Arithmetic belongs to the ALU: results are 4-bit and truncated (ADD mod 16, MUL low nibble). The sequencer never modifies data.
- Reset values:
  - `count` = 0, pointers = 0.
  - `rsp_valid` = 0, `rsp_op` = 0, `rsp_id` = 0.
  - `alu_en` = 0, `cmd_ready` = 1.
  - `alu_a`, `alu_b`, `alu_op` = 0.
- Reset mid-operation: all queued commands and any pending response are discarded with no response emitted. The ALU stage is reset by the same `rst`, so `rsp_data` reads 0.

## Timing
- Idle latency: command handshake at edge k → `alu_en` high during cycle k+1 → issue edge k+1 → `rsp_valid` high from edge k+1, with `rsp_data` valid in the same cycle (the ALU registers on the same edge).
- Command-accept-to-response latency is 1 cycle. The minimum is 1 cycle plus queue wait.
- Sustained rate: 1 command/cycle with `rsp_ready` held high. `count` stays at 1 under continuous one-per-cycle push.
- Backpressure: the response stall propagates to `cmd_ready` only once the queue fills (DEPTH commands buffered).

## Structure
- Shared package `alu_pkg`:
  - Opcode constants `OP_ADD`=2'b00, `OP_AND`=2'b01, `OP_MUL`=2'b10, `OP_OR`=2'b11.
  - `DATA_W`=4.
  - Command struct type {a, b, op, id}.
- One sub-module: `alu_cmd_fifo`, a synchronous DEPTH×entry FIFO with push/pop/count/head outputs. All handshake and issue logic stays in the top.

## Test plan
- Single command: ADD A=9, B=8, id=5 into an idle block → `alu_en` one cycle later, then `rsp_valid` with `rsp_data`=1, `rsp_op`=00, `rsp_id`=5.
- Streaming: MUL 3×7, AND C&A, OR 5|A, ADD F+1 pushed on consecutive cycles with `rsp_ready`=1 → responses on 4 consecutive cycles:
  - data 5, 8, F, 0
  - ids in order
  - `count` ≤ 1 throughout.
- Backpressure: `rsp_ready`=0 while 6 commands are offered → exactly 1 issued, queue reaches 4, `cmd_ready`=0, `alu_en`=0, `rsp_*` stable. Then raise `rsp_ready` → all 5 responses drain in order, 1 per cycle.
- Full with simultaneous pop: queue full with `rsp_ready` toggling → `cmd_ready` stays 0 in the pop cycle and returns to 1 on the next cycle; no command is lost or duplicated.
- Reset mid-stream: assert `rst` for 1 cycle with 3 commands queued and `rsp_valid`=1 → next cycle `count`=0, `rsp_valid`=0, `cmd_ready`=1, and no stale responses afterward.
- Pointer wrap: push 10 commands through with DEPTH=4 under random `rsp_ready` → responses match a scoreboard (4-bit truncated results, ids in order).

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU stage and its command sequencer.
package alu_pkg;

  localparam int DATA_W   = 4;
  localparam int OP_W     = 2;
  localparam int ID_MAX_W = 8;

  localparam logic [OP_W-1:0] OP_ADD = 2'b00;
  localparam logic [OP_W-1:0] OP_AND = 2'b01;
  localparam logic [OP_W-1:0] OP_MUL = 2'b10;
  localparam logic [OP_W-1:0] OP_OR  = 2'b11;

  // The id field is sized for the widest tag; users keep the low ID_W bits.
  typedef struct packed {
    logic [DATA_W-1:0]   a;
    logic [DATA_W-1:0]   b;
    logic [OP_W-1:0]     op;
    logic [ID_MAX_W-1:0] id;
  } cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; occupancy alone decides full and empty.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  cmd_t             wdata,
  output cmd_t             head,
  output logic [CNT_W-1:0] count
);

  cmd_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // NOTE: storage has no reset; count guarantees stale entries are never read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues host commands, issues them to the registered ALU one per cycle and
// holds each result until the response consumer accepts it.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int ID_W  = 3,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [ID_W-1:0]   cmd_id,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  output logic              alu_en,
  input  logic [DATA_W-1:0] alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [OP_W-1:0]   rsp_op,
  output logic [ID_W-1:0]   rsp_id,
  output logic [CNT_W-1:0]  count
);

  cmd_t wr_cmd;
  cmd_t head;
  logic push;
  logic issue;
  logic nonempty;

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (issue),
    .wdata (wr_cmd),
    .head  (head),
    .count (count)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wr_cmd              = '0;
    wr_cmd.a            = cmd_a;
    wr_cmd.b            = cmd_b;
    wr_cmd.op           = cmd_op;
    wr_cmd.id[ID_W-1:0] = cmd_id;
  end

  assign nonempty  = (count != '0);
  assign cmd_ready = (count < CNT_W'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  // Issue only when the ALU result register is free or being consumed now.
  assign issue     = nonempty && (!rsp_valid || rsp_ready);
  assign alu_en    = issue;

  assign alu_a  = nonempty ? head.a  : '0;
  assign alu_b  = nonempty ? head.b  : '0;
  assign alu_op = nonempty ? head.op : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_op    <= '0;
      rsp_id    <= '0;
    end else if (issue) begin
      rsp_valid <= 1'b1;
      rsp_op    <= head.op;
      rsp_id    <= head.id[ID_W-1:0];
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  assign rsp_data = alu_result;

  if (ID_W < ID_MAX_W) begin : g_id_pad
    logic unused_id_hi;
    assign unused_id_hi = ^head.id[ID_MAX_W-1:ID_W];
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural 4-bit registered ALU.
module tb_alu_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int ID_W  = 3;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_a, cmd_b;
  logic [1:0]       cmd_op;
  logic [ID_W-1:0]  cmd_id;
  logic [3:0]       alu_a, alu_b;
  logic [1:0]       alu_op;
  logic             alu_en;
  logic [3:0]       alu_result;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [3:0]       rsp_data;
  logic [1:0]       rsp_op;
  logic [ID_W-1:0]  rsp_id;
  logic [CNT_W-1:0] count;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0]      data;
    logic [1:0]      op;
    logic [ID_W-1:0] id;
  } rsp_t;

  rsp_t exp_q[$];

  always #5 clk = ~clk;

  function automatic logic [3:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                         input logic [1:0] op);
    logic [7:0] p;
    p = a * b;
    case (op)
      2'b00:   return a + b;
      2'b01:   return a & b;
      2'b10:   return p[3:0];
      default: return a | b;
    endcase
  endfunction

  // Registered ALU stage, reset by the same rst as the sequencer.
  always @(posedge clk) begin
    if (rst) alu_result <= 4'h0;
    else if (alu_en) alu_result <= alu_ref(alu_a, alu_b, alu_op);
  end

  alu_cmd_sequencer #(.DEPTH(DEPTH), .ID_W(ID_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_op     (cmd_op),
    .cmd_id     (cmd_id),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_en     (alu_en),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_op     (rsp_op),
    .rsp_id     (rsp_id),
    .count      (count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input int k);
    cmd_a  = 4'(k * 3 + 1);
    cmd_b  = 4'(15 - k);
    cmd_op = 2'(k);
    cmd_id = 3'(k + 2);
  endtask

  function automatic rsp_t make_exp(input int k);
    rsp_t e;
    e.data = alu_ref(4'(k * 3 + 1), 4'(15 - k), 2'(k));
    e.op   = 2'(k);
    e.id   = 3'(k + 2);
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_id = '0;
    rsp_ready = 1'b0;
    step(); step();
    checks++; if (count !== 0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_op !== 2'b00 || rsp_id !== 3'd0) begin failures++; $display("FAIL reset_rsp_tag got=op%0d/id%0d exp=op0/id0", rsp_op, rsp_id); end
    checks++; if (alu_en !== 1'b0) begin failures++; $display("FAIL reset_alu_en got=%b exp=0", alu_en); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    checks++; if ({alu_a, alu_b, alu_op} !== 10'd0) begin failures++; $display("FAIL reset_alu_operands got=%h/%h/%h exp=0/0/0", alu_a, alu_b, alu_op); end
    checks++; if (rsp_data !== 4'h0) begin failures++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    cmd_valid = 1'b1; cmd_a = 4'd9; cmd_b = 4'd8; cmd_op = 2'b00; cmd_id = 3'd5;
    rsp_ready = 1'b1;
    #1;
    checks++; if (alu_en !== 1'b0) begin failures++; $display("FAIL single_no_bypass got=%b exp=0", alu_en); end
    step();
    cmd_valid = 1'b0;
    #1;
    checks++; if (alu_en !== 1'b1) begin failures++; $display("FAIL single_issue got=%b exp=1", alu_en); end
    checks++; if (alu_a !== 4'd9 || alu_b !== 4'd8 || alu_op !== 2'b00) begin failures++; $display("FAIL single_operands got=%h/%h/%h exp=9/8/0", alu_a, alu_b, alu_op); end
    checks++; if (count !== 1 || rsp_valid !== 1'b0) begin failures++; $display("FAIL single_queued got=count%0d/v%b exp=count1/v0", count, rsp_valid); end
    step();
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL single_rsp_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_data !== 4'h1 || rsp_op !== 2'b00 || rsp_id !== 3'd5) begin failures++; $display("FAIL single_rsp got=d%h/op%0d/id%0d exp=d1/op0/id5", rsp_data, rsp_op, rsp_id); end
    checks++; if (count !== 0 || alu_en !== 1'b0) begin failures++; $display("FAIL single_empty got=count%0d/en%b exp=count0/en0", count, alu_en); end
    step();
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_retire got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_streaming();
    logic [3:0] sa [4] = '{4'h3, 4'hC, 4'h5, 4'hF};
    logic [3:0] sb [4] = '{4'h7, 4'hA, 4'hA, 4'h1};
    logic [1:0] so [4] = '{2'b10, 2'b01, 2'b11, 2'b00};
    logic [2:0] si [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
    logic [3:0] sd [4] = '{4'h5, 4'h8, 4'hF, 4'h0};
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        cmd_valid = 1'b1; cmd_a = sa[i]; cmd_b = sb[i]; cmd_op = so[i]; cmd_id = si[i];
      end else begin
        cmd_valid = 1'b0;
      end
      step();
      checks++; if (count > 1) begin failures++; $display("FAIL stream_count cycle=%0d got=%0d exp<=1", i, count); end
      if (i >= 1) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== sd[i-1] || rsp_op !== so[i-1] || rsp_id !== si[i-1]) begin
          failures++;
          $display("FAIL stream_rsp%0d got=v%b/d%h/op%0d/id%0d exp=v1/d%h/op%0d/id%0d",
                   i-1, rsp_valid, rsp_data, rsp_op, rsp_id, sd[i-1], so[i-1], si[i-1]);
        end
      end
    end
    step();
    checks++; if (rsp_valid !== 1'b0 || count !== 0) begin failures++; $display("FAIL stream_idle got=v%b/count%0d exp=v0/count0", rsp_valid, count); end
  endtask

  task automatic test_backpressure();
    logic [3:0] ba [6] = '{4'd2, 4'd6, 4'd4, 4'd9, 4'd7, 4'd1};
    logic [3:0] bb [6] = '{4'd3, 4'd3, 4'd4, 4'd6, 4'd7, 4'd1};
    logic [1:0] bo [6] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b00};
    logic [3:0] bd [6] = '{4'h5, 4'h2, 4'h0, 4'hF, 4'hE, 4'h2};
    int   idx    = 0;
    int   issued = 0;
    logic hs;
    rsp_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      cmd_valid = (idx < 6);
      if (idx < 6) begin
        cmd_a = ba[idx]; cmd_b = bb[idx]; cmd_op = bo[idx]; cmd_id = 3'(idx);
      end
      #1;
      if (alu_en) issued++;
      hs = cmd_valid && cmd_ready;
      step();
      if (hs) idx++;
      if (issued > 0) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 3'd0 || rsp_data !== 4'h5 || rsp_op !== 2'b00) begin
          failures++;
          $display("FAIL bp_stall_stable cycle=%0d got=v%b/d%h/id%0d exp=v1/d5/id0", c, rsp_valid, rsp_data, rsp_id);
        end
      end
    end
    cmd_valid = 1'b0;
    #1;
    checks++; if (issued !== 1) begin failures++; $display("FAIL bp_issued got=%0d exp=1", issued); end
    checks++; if (idx !== 5) begin failures++; $display("FAIL bp_accepted got=%0d exp=5", idx); end
    checks++; if (count !== 4 || cmd_ready !== 1'b0 || alu_en !== 1'b0) begin failures++; $display("FAIL bp_full got=count%0d/rdy%b/en%b exp=count4/rdy0/en0", count, cmd_ready, alu_en); end
    rsp_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 3'(j) || rsp_data !== bd[j] || rsp_op !== bo[j]) begin
        failures++;
        $display("FAIL bp_drain%0d got=v%b/d%h/op%0d/id%0d exp=v1/d%h/op%0d/id%0d",
                 j, rsp_valid, rsp_data, rsp_op, rsp_id, bd[j], bo[j], j);
      end
      step();
    end
    checks++; if (rsp_valid !== 1'b0 || count !== 0) begin failures++; $display("FAIL bp_done got=v%b/count%0d exp=v0/count0", rsp_valid, count); end
  endtask

  task automatic test_full_pop();
    int   idx = 0;
    logic hs;
    rsp_t e;
    exp_q.delete();
    rsp_ready = 1'b0;
    for (int c = 0; c < 20 && idx < 5; c++) begin
      cmd_valid = 1'b1; drive_cmd(idx);
      #1;
      hs = cmd_valid && cmd_ready;
      step();
      if (hs) begin exp_q.push_back(make_exp(idx)); idx++; end
    end
    checks++; if (count !== 4 || cmd_ready !== 1'b0) begin failures++; $display("FAIL full_fill got=count%0d/rdy%b exp=count4/rdy0", count, cmd_ready); end
    cmd_valid = 1'b1; drive_cmd(5); rsp_ready = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b0 || alu_en !== 1'b1) begin failures++; $display("FAIL full_pop_cycle got=rdy%b/en%b exp=rdy0/en1", cmd_ready, alu_en); end
    e = exp_q.pop_front();
    checks++; if ({rsp_data, rsp_op, rsp_id} !== e) begin failures++; $display("FAIL full_first_rsp got=d%h/id%0d exp=d%h/id%0d", rsp_data, rsp_id, e.data, e.id); end
    step();
    checks++; if (count !== 3 || cmd_ready !== 1'b1) begin failures++; $display("FAIL full_after_pop got=count%0d/rdy%b exp=count3/rdy1", count, cmd_ready); end
    rsp_ready = 1'b0;
    #1;
    hs = cmd_valid && cmd_ready;
    step();
    if (hs) exp_q.push_back(make_exp(5));
    cmd_valid = 1'b0;
    checks++; if (count !== 4) begin failures++; $display("FAIL full_refill got=%0d exp=4", count); end
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
      rsp_ready = (c % 3 != 1);
      #1;
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL full_dup got=id%0d exp=none", rsp_id);
        end else begin
          e = exp_q.pop_front();
          if ({rsp_data, rsp_op, rsp_id} !== e) begin
            failures++;
            $display("FAIL full_drain got=d%h/op%0d/id%0d exp=d%h/op%0d/id%0d", rsp_data, rsp_op, rsp_id, e.data, e.op, e.id);
          end
        end
      end
      step();
    end
    checks++; if (exp_q.size() != 0 || rsp_valid !== 1'b0 || count !== 0) begin failures++; $display("FAIL full_lost got=left%0d/v%b/count%0d exp=left0/v0/count0", exp_q.size(), rsp_valid, count); end
  endtask

  task automatic test_reset_mid();
    int   idx = 0;
    logic hs;
    logic stale = 1'b0;
    rsp_ready = 1'b0;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      cmd_valid = 1'b1; drive_cmd(idx + 9);
      #1;
      hs = cmd_valid && cmd_ready;
      step();
      if (hs) idx++;
    end
    cmd_valid = 1'b0;
    checks++; if (count !== 3 || rsp_valid !== 1'b1) begin failures++; $display("FAIL rstmid_setup got=count%0d/v%b exp=count3/v1", count, rsp_valid); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (count !== 0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin failures++; $display("FAIL rstmid_state got=count%0d/v%b/rdy%b exp=count0/v0/rdy1", count, rsp_valid, cmd_ready); end
    checks++; if (rsp_data !== 4'h0 || alu_en !== 1'b0) begin failures++; $display("FAIL rstmid_data got=d%h/en%b exp=d0/en0", rsp_data, alu_en); end
    rsp_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      if (rsp_valid || alu_en) stale = 1'b1;
    end
    checks++; if (stale !== 1'b0) begin failures++; $display("FAIL rstmid_stale got=%b exp=0", stale); end
  endtask

  task automatic test_wrap();
    int   idx = 0;
    int   got = 0;
    logic hs;
    rsp_t e;
    exp_q.delete();
    for (int c = 0; c < 200 && got < 10; c++) begin
      cmd_valid = (idx < 10);
      drive_cmd(idx + 7);
      rsp_ready = 1'($urandom_range(0, 1));
      #1;
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL wrap_dup got=id%0d exp=none", rsp_id);
        end else begin
          e = exp_q.pop_front();
          if ({rsp_data, rsp_op, rsp_id} !== e) begin
            failures++;
            $display("FAIL wrap_rsp%0d got=d%h/op%0d/id%0d exp=d%h/op%0d/id%0d", got, rsp_data, rsp_op, rsp_id, e.data, e.op, e.id);
          end
        end
        got++;
      end
      hs = cmd_valid && cmd_ready;
      step();
      if (hs) begin exp_q.push_back(make_exp(idx + 7)); idx++; end
    end
    cmd_valid = 1'b0;
    checks++; if (got !== 10 || idx !== 10) begin failures++; $display("FAIL wrap_total got=rsp%0d/push%0d exp=rsp10/push10", got, idx); end
    checks++; if (count !== 0 || rsp_valid !== 1'b0) begin failures++; $display("FAIL wrap_idle got=count%0d/v%b exp=count0/v0", count, rsp_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_streaming();
    test_backpressure();
    test_full_pop();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
